icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache line (power of 2, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port miss_req  input  1  fetch-miss request, sampled only in IDLE.
REQ-006 SHALL have port miss_addr  input  ADDR_W  missing byte address.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port refill_done  output  1  one-cycle pulse at line completion.
REQ-009 SHALL have ports arvalid out 1, araddr out ADDR_W, arlen out 8, arready in 1  burst read-address channel.
REQ-010 SHALL have ports rvalid in 1, rdata in 32, rlast in 1, rready out 1  read-data channel.
REQ-011 SHALL have ports ram_en out 1, ram_wen out 4, ram_addr out ADDR_W, ram_wdata out 32  data-RAM write port.
REQ-012 SHALL have ports tag_wen out 1, tag_addr out ADDR_W  tag/valid write strobe and line base address.
REQ-013 SHALL have port proto_err  output  1  sticky rlast-mismatch flag.

Function
REQ-014 SHALL implement FSM states IDLE, AR, R, DONE.
REQ-015 IDLE: when miss_req=1, SHALL latch line_base = miss_addr with low log2(LINE_WORDS)+2 bits cleared, clear beat counter, go to AR next cycle.
REQ-016 AR: SHALL drive arvalid=1, araddr=line_base, arlen=LINE_WORDS-1, held stable until the cycle arready=1, then go to R.
REQ-017 R: SHALL drive rready=1; a beat is any cycle with rvalid=1 in R.
REQ-018 Per beat, same cycle, combinationally: ram_en=1, ram_wen=4'hF, ram_wdata=rdata, ram_addr=line_base+4*cnt; cnt increments.
REQ-019 Beat with cnt=LINE_WORDS-1 SHALL be the last; FSM goes to DONE next cycle; completion counted by beats, not rlast.
REQ-020 If rlast=1 on a beat with cnt!=LINE_WORDS-1, or rlast=0 on the final beat, proto_err SHALL set and stay set until reset.
REQ-021 DONE: refill_done=1, tag_wen=1, tag_addr=line_base for exactly one cycle, then IDLE.
REQ-022 Outside their qualifying states, arvalid, rready, ram_en, ram_wen, tag_wen, refill_done SHALL be 0.
REQ-023 miss_req while busy SHALL be ignored; miss_req in the DONE cycle is not accepted (accepted earliest in following IDLE cycle).
REQ-024 rvalid in IDLE/AR/DONE SHALL cause no RAM write and no counter change.
REQ-025 Cycles in R with rvalid=0 SHALL hold cnt and produce no write (gaps allowed between beats).
REQ-026 Minimum miss-to-done latency: 1 (IDLE->AR) + 1 (arready) + LINE_WORDS beats + 1 = LINE_WORDS+3 cycles, zero-wait-state slave.

Reset
REQ-027 When rst=0 at a clock edge, FSM SHALL go to IDLE, cnt=0, line_base=0, proto_err=0, all outputs 0, regardless of state.
REQ-028 Reset mid-burst SHALL abandon the line: no tag_wen, no refill_done; remaining beats after release are ignored per REQ-024.

Verification
REQ-029 miss_addr=0x0000_1234, arready=1 immediately, 8 back-to-back beats 0xA0..0xA7, rlast on 8th -> araddr=0x1220, arlen=7, writes 0x1220..0x123C, refill_done+tag_wen at cycle 11, tag_addr=0x1220, proto_err=0.
REQ-030 arready delayed 5 cycles, rvalid toggled 1/0 -> araddr stable during wait, exactly 8 writes at consecutive addresses, done one cycle after 8th beat.
REQ-031 rlast asserted on beat 4 -> proto_err=1, refill still completes after beat 8, proto_err held until rst=0.
REQ-032 rst=0 for one cycle after beat 3 -> outputs 0, IDLE; subsequent rvalid beats produce ram_en=0; no refill_done.
REQ-033 miss_req held high continuously, addresses 0x40 then 0x80 -> second burst araddr=0x80 issued only after refill_done cycle plus one IDLE cycle.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: on a fetch miss, issues one burst read
// for the whole line, streams each returned beat into the data RAM, then
// writes the tag/valid entry for the line base and pulses refill_done.
module icache_refill #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              busy,
    output logic              refill_done,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    output logic              rready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              tag_wen,
    output logic [ADDR_W-1:0] tag_addr,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] line_base_q;
    logic              proto_err_q;

    // Refill sequencing: accept a miss, wait for the address handshake,
    // count beats until the line is full, then spend one cycle on the tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_base_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_req) begin
                        line_base_q <= miss_addr & ~OFF_MASK;
                        cnt_q       <= '0;
                        state_q     <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        state_q <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Completion is decided by beat count; rlast is only audited.
                        if (rlast != (cnt_q == LAST_CNT)) begin
                            proto_err_q <= 1'b1;
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode: channel strobes follow the state, RAM writes follow each accepted beat.
    always_comb begin
        busy        = (state_q != IDLE);
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        rready      = 1'b0;
        ram_en      = 1'b0;
        ram_wen     = '0;
        ram_addr    = '0;
        ram_wdata   = '0;
        tag_wen     = 1'b0;
        tag_addr    = '0;
        refill_done = 1'b0;
        proto_err   = proto_err_q;
        case (state_q)
            AR: begin
                arvalid = 1'b1;
                araddr  = line_base_q;
                arlen   = BURST_LEN;
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    ram_en    = 1'b1;
                    ram_wen   = '1;
                    ram_wdata = rdata;
                    ram_addr  = line_base_q + (ADDR_W'(cnt_q) << 2);
                end
            end
            DONE: begin
                refill_done = 1'b1;
                tag_wen     = 1'b1;
                tag_addr    = line_base_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: randomized refills driven against a line-level
// reference model; expected AR requests, RAM writes and tag writes are queued
// by the driver and consumed by an independent negedge monitor.
module tb_icache_refill;

    localparam int LW = 8;
    localparam logic [31:0] BASE_MASK = ~32'(LW * 4 - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        busy;
    logic        refill_done;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rready;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        tag_wen;
    logic [31:0] tag_addr;
    logic        proto_err;

    icache_refill #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .refill_done(refill_done),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .tag_wen(tag_wen), .tag_addr(tag_addr), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          fin;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] arq[$];
    logic [31:0] dq[$];

    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   t_issue = 0;
    bit   exp_perr = 1'b0;
    bit   prev_final = 1'b0;
    logic [31:0] cur_base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every DUT-presented event is matched against the queued model output.
    always @(negedge clk) begin
        wr_t w;
        bit  fin_now;
        fin_now = 1'b0;
        if (ram_en) begin
            if (wq.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", ram_addr, ram_wdata);
            end else begin
                w = wq.pop_front();
                chk("ram_addr", ram_addr, w.addr);
                chk("ram_wdata", ram_wdata, w.data);
                chk("ram_wen", {28'd0, ram_wen}, 32'hF);
                chk("rready_on_beat", {31'd0, rready}, 32'd1);
                fin_now = w.fin;
            end
        end
        if (arvalid) begin
            if (arq.size() == 0) begin
                total++;
                $display("FAIL unexpected_ar: araddr 0x%08h, none expected", araddr);
            end else begin
                chk(arready ? "araddr_hs" : "araddr_wait", araddr, arq[0]);
                chk("arlen", {24'd0, arlen}, LW - 1);
                if (arready) void'(arq.pop_front());
            end
        end
        if (refill_done || tag_wen) begin
            chk("tag_wen_eq_done", {31'd0, tag_wen}, {31'd0, refill_done});
            if (dq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: tag_addr 0x%08h, none expected", tag_addr);
            end else begin
                chk("tag_addr", tag_addr, dq.pop_front());
                chk("done_after_last_beat", {31'd0, prev_final}, 32'd1);
                chk("proto_err_at_done", {31'd0, proto_err}, {31'd0, exp_perr});
            end
        end
        prev_final = fin_now;
    end

    task automatic noise(input bit hold);
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
        rlast  = 1'($urandom_range(0, 1));
        if (!hold) miss_req = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_miss(input logic [31:0] a, input bit hold);
        miss_req = 1'b1;
        miss_addr = a;
        cur_base = a & BASE_MASK;
        arq.push_back(cur_base);
        t_issue = cyc;
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
        rlast  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (!hold) begin
            miss_req = 1'b0;
            miss_addr = $urandom;
        end
    endtask

    task automatic addr_phase(input int dly, input bit hold);
        int n;
        n = 0;
        while (!arvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!arvalid) begin
            total++;
            $display("FAIL ar_timeout: arvalid 0 after %0d cycles, required 1", n);
        end
        for (int d = 0; d < dly; d++) begin
            arready = 1'b0;
            noise(hold);
            @(posedge clk); #1;
        end
        arready = 1'b1;
        noise(hold);
        @(posedge clk); #1;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        if (!hold) miss_req = 1'b0;
    endtask

    // errbeat: beat index whose rlast is inverted from the correct value (-1: none).
    task automatic data_phase(input int nbeats, input int gapmax, input int errbeat,
                              input bit seq, input bit hold);
        for (int i = 0; i < nbeats; i++) begin
            bit          fin;
            bit          rl;
            logic [31:0] d;
            int          gaps;
            gaps = $urandom_range(0, gapmax);
            for (int g = 0; g < gaps; g++) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rlast  = 1'($urandom_range(0, 1));
                if (!hold) miss_req = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            fin = (i == LW - 1);
            rl  = fin;
            if (i == errbeat) rl = !rl;
            d = seq ? 32'hA0 + 32'(i) : $urandom;
            rvalid = 1'b1;
            rdata  = d;
            rlast  = rl;
            if (!hold && fin) miss_req = 1'b0;
            wq.push_back('{addr: cur_base + 32'(4 * i), data: d, fin: fin});
            if (fin) dq.push_back(cur_base);
            @(posedge clk); #1;
            if (rl != fin) exp_perr = 1'b1;
        end
        rvalid = 1'b0;
        rlast = 1'b0;
    endtask

    task automatic refill(input logic [31:0] a, input int dly, input int gapmax, input int errbeat);
        issue_miss(a, 1'b0);
        addr_phase(dly, 1'b0);
        data_phase(LW, gapmax, errbeat, 1'b0, 1'b0);
        chk("done_pulse", {31'd0, refill_done}, 32'd1);
        miss_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, refill_done}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_rready"}, {31'd0, rready}, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_tag_wen"}, {31'd0, tag_wen}, 32'd0);
        chk({tag, "_done"}, {31'd0, refill_done}, 32'd0);
        chk({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; miss_req = 1'b0; miss_addr = '0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0; rlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait reference line at 0x1234.
        issue_miss(32'h0000_1234, 1'b0);
        addr_phase(0, 1'b0);
        data_phase(LW, 0, -1, 1'b1, 1'b0);
        chk("latency_edges", 32'(cyc - t_issue), 32'(LW + 2));
        chk("ref_done", {31'd0, refill_done}, 32'd1);
        chk("ref_tag_addr", tag_addr, 32'h0000_1220);
        chk("ref_proto_err", {31'd0, proto_err}, 32'd0);
        @(posedge clk); #1;
        chk("ref_idle", {31'd0, busy}, 32'd0);

        // Slow arready and gapped data.
        refill($urandom, 5, 1, -1);

        // miss_req held high: second miss accepted only after DONE plus one IDLE cycle.
        issue_miss(32'h0000_0040, 1'b1);
        addr_phase(0, 1'b1);
        data_phase(LW, 0, -1, 1'b0, 1'b1);
        chk("hold_done", {31'd0, refill_done}, 32'd1);
        miss_addr = 32'h0000_0080;
        cur_base = 32'h0000_0080;
        arq.push_back(32'h0000_0080);
        @(posedge clk); #1;
        chk("hold_idle_arvalid", {31'd0, arvalid}, 32'd0);
        chk("hold_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("hold_second_arvalid", {31'd0, arvalid}, 32'd1);
        chk("hold_second_araddr", araddr, 32'h0000_0080);
        miss_req = 1'b0;
        addr_phase(0, 1'b0);
        data_phase(LW, 0, -1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Early rlast on beat 4: error flagged, line still completes, flag sticks.
        refill($urandom, 1, 1, 3);
        chk("perr_set", {31'd0, proto_err}, 32'd1);
        for (int k = 0; k < 6; k++) refill($urandom, $urandom_range(0, 4), $urandom_range(0, 3), -1);
        chk("perr_sticky", {31'd0, proto_err}, 32'd1);

        // Reset after beat 3 abandons the line; later beats must not write.
        issue_miss($urandom, 1'b0);
        addr_phase(1, 1'b0);
        data_phase(3, 1, -1, 1'b0, 1'b0);
        rst = 1'b0;
        miss_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_perr = 1'b0;
        check_quiet("midreset");
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1;
            rdata = $urandom;
            rlast = (k == 2);
            #1;
            chk("postreset_ram_en", {31'd0, ram_en}, 32'd0);
            @(posedge clk); #1;
            chk("postreset_done", {31'd0, refill_done}, 32'd0);
        end
        rvalid = 1'b0;
        rlast = 1'b0;

        // Randomized traffic including a missing final rlast.
        for (int k = 0; k < 12; k++) begin
            int eb;
            eb = (k == 8) ? LW - 1 : -1;
            refill($urandom, $urandom_range(0, 4), $urandom_range(0, 3), eb);
        end
        chk("perr_missing_last", {31'd0, proto_err}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("ar_drained", 32'(arq.size()), 32'd0);
        chk("done_drained", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
